// File: rtl/pi_if.sv
// pi_if: PI stage bus; error sample, gains and integrator controls in; clamped output and status out.
interface pi_if #(
    parameter int IW = 14,
    parameter int GW = 12,
    parameter int OW = 15
);
    logic                 in_valid;
    logic signed [IW-1:0] error;
    logic signed [GW-1:0] kp;
    logic signed [GW-1:0] ki;
    logic                 hold;
    logic                 irst;
    logic signed [OW-1:0] out;
    logic                 out_valid;
    logic                 int_sat;
    modport master (output in_valid, error, kp, ki, hold, irst, input out, out_valid, int_sat);
    modport slave  (input in_valid, error, kp, ki, hold, irst, output out, out_valid, int_sat);
endinterface

// File: rtl/pi_integrator.sv
// pi_integrator: 3-stage PI controller with anti-windup clamped integrator and clamped OW-bit output.
// Define PI_ROUND_EN to round both right shifts half-up instead of truncating.
module pi_integrator #(
    parameter int IW  = 14,
    parameter int GW  = 12,
    parameter int KSH = 10,
    parameter int ISH = 16,
    parameter int OW  = 15,
    parameter int AW  = 32
) (
    input logic clk,
    input logic rst,
    pi_if.slave bus
);
    localparam int PW = IW + GW;
    localparam int SW = OW + 2;
    localparam logic signed [AW:0] ACC_MAX = {{(AW-OW-ISH+2){1'b0}}, {(OW-1+ISH){1'b1}}};
    localparam logic signed [AW:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [SW-1:0] OUT_MAX = {3'b000, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] OUT_MIN = ~OUT_MAX;
    logic                 v1, v2;
    logic signed [PW-1:0] p, inc, pt, pt_n;
    logic signed [AW-1:0] acc;
    logic signed [AW:0]   nxt, acc_n, ai;
    logic signed [SW-1:0] sum;
    logic                 sat;
    always_comb begin
        nxt   = (AW+1)'(acc) + (AW+1)'(inc);
        sat   = nxt > ACC_MAX || nxt < ACC_MIN;
        acc_n = nxt > ACC_MAX ? ACC_MAX : nxt < ACC_MIN ? ACC_MIN : nxt;
`ifdef PI_ROUND_EN
        pt_n  = PW'(((PW+1)'(p) + (PW+1)'(1 <<< (KSH-1))) >>> KSH);
        ai    = ((AW+1)'(acc) + (AW+1)'(1 <<< (ISH-1))) >>> ISH;
`else
        pt_n  = p >>> KSH;
        ai    = (AW+1)'(acc) >>> ISH;
`endif
        sum   = SW'(pt) + SW'(ai);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            p             <= '0;
            inc           <= '0;
            pt            <= '0;
            acc           <= '0;
            bus.int_sat   <= 1'b0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                p   <= PW'(bus.error) * PW'(bus.kp);
                inc <= PW'(bus.error) * PW'(bus.ki);
            end
            v2 <= v1;
            if (v1) pt <= pt_n;
            // irst clears regardless of a pending update; hold only freezes the integrator
            if (bus.irst) begin
                acc         <= '0;
                bus.int_sat <= 1'b0;
            end else if (v1 && !bus.hold) begin
                acc         <= AW'(acc_n);
                bus.int_sat <= sat;
            end
            bus.out_valid <= v2;
            if (v2) bus.out <= OW'(sum > OUT_MAX ? OUT_MAX : sum < OUT_MIN ? OUT_MIN : sum);
        end
    end
endmodule
